// File: rtl/pcode_fetch_arb.sv
// Round-robin arbiter sharing one single-port P-code ROM between N_REQ chip channels.
// Latency: req sampled in cycle T -> gnt/rom_addr in T+1 -> rsp_valid/rsp_data in T+3.
// No backpressure: one grant per cycle at most, responses always accepted; a granted channel sits out one cycle.
module pcode_fetch_arb #(
  parameter int N_REQ = 4,
  parameter int AW    = 16,
  parameter int DW    = 8,
  parameter int DEPTH = 40960
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] addr,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic                rsp_err,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data
);

  localparam int PW = $clog2(N_REQ);
  // One extra bit so DEPTH == 2^AW still compares correctly.
  localparam logic [32:0] DEPTH_L = 33'(DEPTH);

  logic [N_REQ-1:0] elig;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    cand;
  logic [PW-1:0]    win_id;
  logic             win_vld;
  logic [PW-1:0]    ptr_nxt;
  logic [AW-1:0]    win_addr;
  logic             win_oor;

  // Read pipeline tags: S0 (address issued), S1 (ROM registering address)
  logic             v0, v1;
  logic             err0, err1;
  logic [PW-1:0]    id0, id1;

  // Channel index increment with wrap at N_REQ (N_REQ need not be a power of two).
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(N_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] i);
    logic [N_REQ-1:0] o;
    o    = '0;
    o[i] = 1'b1;
    return o;
  endfunction

  // A channel whose grant is showing this cycle is still presenting the granted
  // address, so it is masked out until it has had a cycle to move on.
  assign elig = req & ~gnt;

  // Pick the first eligible channel at or after rr_ptr, wrapping around.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // Winner's address and range check; out-of-range reads never reach the ROM.
  always_comb begin
    ptr_nxt  = wrap_inc(win_id);
    win_addr = addr[win_id*AW +: AW];
    win_oor  = ({{(33-AW){1'b0}}, win_addr} >= DEPTH_L);
  end

  // Round-robin pointer moves just past each winner and holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (win_vld) begin
      rr_ptr <= ptr_nxt;
    end
  end

  // S0: grant pulse, ROM address and the tag that follows the read down the pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt      <= '0;
      rom_addr <= '0;
      v0       <= 1'b0;
      id0      <= '0;
      err0     <= 1'b0;
    end else begin
      v0 <= win_vld;
      if (win_vld) begin
        gnt  <= onehot(win_id);
        id0  <= win_id;
        err0 <= win_oor;
        if (!win_oor) begin
          rom_addr <= win_addr;
        end
      end else begin
        gnt <= '0;
      end
    end
  end

  // S1: tag waits while the ROM registers rom_addr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      id1  <= '0;
      err1 <= 1'b0;
    end else begin
      v1   <= v0;
      id1  <= id0;
      err1 <= err0;
    end
  end

  // S2: route the ROM word back to its channel; errored reads return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= v1 ? onehot(id1) : '0;
      rsp_err   <= v1 & err1;
      if (v1) begin
        rsp_data <= err1 ? '0 : rom_data;
      end
    end
  end

endmodule
